// File: rtl/led_drv_pkg.sv
// Shared types and constants for the LED pattern driver.
// Gamma mapping is used when LED_DRV_GAMMA_EN is defined.
package led_drv_pkg;

  localparam int NUM_LEDS = 4;

  typedef logic [7:0] duty_t;

  typedef enum logic [1:0] {
    MODE_FOLLOW    = 2'b00,
    MODE_BLINK     = 2'b01,
    MODE_PWM       = 2'b10,
    MODE_PWM_BLINK = 2'b11
  } mode_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  // Square-law brightness curve: (d*d) >> 8, so 255 -> 254 and 16 -> 1.
  function automatic duty_t gamma_map(input duty_t d);
    logic [15:0] p;
    p = {8'b0, d} * {8'b0, d};
    return p[15:8];
  endfunction

endpackage

// File: rtl/led_pattern_driver_if.sv
// Avalon-MM register port of the LED pattern driver (zero wait states).
interface led_pattern_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_pwm_timebase.sv
// Shared PWM timebase: prescaler, 8-bit PWM step counter and blink phase.
module led_pwm_timebase
  import led_drv_pkg::*;
#(
  parameter int PRESCALE  = 195,
  parameter int BLINK_DIV = 250
) (
  input  logic  clk,
  input  logic  reset_n,
  output logic  tick,
  output logic  wrap,
  output duty_t pwm_cnt,
  output logic  blink_phase
);

  localparam int PW = $clog2(PRESCALE);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] pre_cnt;
  logic [BW-1:0] blink_cnt;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));
  assign wrap = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) begin
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// LED pattern driver: follow / blink / PWM / PWM-blink per LED, Avalon-MM configured.
// Define LED_DRV_GAMMA_EN to load shadowed duties through the square-law curve.
module led_pattern_driver
  import led_drv_pkg::*;
#(
  parameter int PRESCALE  = 195,
  parameter int BLINK_DIV = 250
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_LEDS-1:0]   led_req,
  led_pattern_driver_if.slave   bus,
  output logic [NUM_LEDS-1:0]   led_out
);

  logic        tick_unused;
  logic        wrap;
  duty_t       pwm_cnt;
  logic        blink_phase;
  logic [7:0]  ctrl;
  duty_t       duty_reg [NUM_LEDS];
  duty_t       duty_eff [NUM_LEDS];
  logic        wrap_seen;
  logic        wr;
  logic [NUM_LEDS-1:0] led_next;

  led_pwm_timebase #(
    .PRESCALE  (PRESCALE),
    .BLINK_DIV (BLINK_DIV)
  ) u_timebase (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick_unused),
    .wrap        (wrap),
    .pwm_cnt     (pwm_cnt),
    .blink_phase (blink_phase)
  );

  function automatic duty_t shadow_map(input duty_t d);
`ifdef LED_DRV_GAMMA_EN
    return gamma_map(d);
`else
    return d;
`endif
  endfunction

  assign wr = bus.chipselect && !bus.write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl      <= '0;
      wrap_seen <= 1'b0;
      led_out   <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty_reg[i] <= '0;
        duty_eff[i] <= '0;
      end
    end else begin
      if (wr && bus.address == ADDR_CTRL) ctrl <= bus.writedata[7:0];
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr && bus.address == ADDR_DUTY) duty_reg[i] <= bus.writedata[8*i +: 8];
        // Shadow load sees the pre-write duty_reg when a write lands on the wrap.
        if (wrap) duty_eff[i] <= shadow_map(duty_reg[i]);
      end
      // A wrap in the clearing cycle wins so the event is never lost.
      if (wrap) wrap_seen <= 1'b1;
      else if (wr && bus.address == ADDR_STATUS) wrap_seen <= 1'b0;
      led_out <= led_next;
    end
  end

  always_comb begin
    mode_e mode;
    logic  pwm_on;
    led_next = '0;
    mode     = MODE_FOLLOW;
    pwm_on   = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      mode   = mode_e'(ctrl[2*i +: 2]);
      pwm_on = (pwm_cnt < duty_eff[i]);
      case (mode)
        MODE_FOLLOW:    led_next[i] = led_req[i];
        MODE_BLINK:     led_next[i] = led_req[i] & blink_phase;
        MODE_PWM:       led_next[i] = led_req[i] & pwm_on;
        MODE_PWM_BLINK: led_next[i] = led_req[i] & blink_phase & pwm_on;
        default:        led_next[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (bus.chipselect) begin
      case (bus.address)
        ADDR_CTRL:   bus.readdata = {24'b0, ctrl};
        ADDR_DUTY:   bus.readdata = {duty_reg[3], duty_reg[2], duty_reg[1], duty_reg[0]};
        ADDR_STATUS: bus.readdata = {26'b0, blink_phase, wrap_seen, led_out};
        default:     bus.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with PRESCALE=2, BLINK_DIV=4 (512 clocks per PWM period).
module tb_led_pattern_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] led_req;
  logic [3:0] led_out;

  led_pattern_driver_if bus ();

  led_pattern_driver #(
    .PRESCALE  (2),
    .BLINK_DIV (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .led_req (led_req),
    .bus     (bus),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release; edge k is the k-th posedge.
  int cyc = 0;
  int lit_total = 0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Counts LED0 lit states; a snapshot at cycle c covers states after edges < c.
  always @(posedge clk) begin
    if (led_out[0] === 1'b1) lit_total <= lit_total + 1;
  end

  function automatic int exp_lit(input int d);
`ifdef LED_DRV_GAMMA_EN
    return 2 * ((d * d) >> 8);
`else
    return 2 * d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      vectors++;
      miscompares++;
      $error("FAIL wait_cyc: reached cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = data;
    @(posedge clk);
    @(negedge clk);
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] addr, input string tag, input logic [31:0] exp);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    check(tag, bus.readdata, exp);
  endtask

  initial begin
    int s0, s1, a, b, c, d, e, f, g, h, i, j, k;
    int len;
    led_req        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    repeat (3) @(negedge clk);
    check("reset_led_out", {28'b0, led_out}, 32'h0);
    reset_n = 1'b1;

    wait_cyc(1);
    check("follow_after_release", {28'b0, led_out}, 32'hF);
    rd(2'd2, "status_reset", 32'h0000_000F);
    rd(2'd0, "ctrl_reset", 32'h0);
    rd(2'd1, "duty_reset", 32'h0);
    rd(2'd3, "addr3_reset", 32'h0);

    // All LEDs blink.
    bus_write(2'd0, 32'h55);
    wait_cyc(3);
    check("blink_phase0_dark", {28'b0, led_out}, 32'h0);
    rd(2'd0, "ctrl_blink_rd", 32'h55);
    wait_cyc(100);
    bus_write(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, "addr3_ignored", 32'h0);

    wait_cyc(511);
    rd(2'd2, "status_before_wrap", 32'h00);
    wait_cyc(512);
    rd(2'd2, "status_wrap_seen", 32'h10);
    wait_cyc(2048);
    check("blink_last_dark", {28'b0, led_out}, 32'h0);
    rd(2'd2, "status_phase1", 32'h30);
    wait_cyc(2049);
    check("blink_first_lit", {28'b0, led_out}, 32'hF);
    rd(2'd2, "status_phase1_lit", 32'h3F);
    wait_cyc(4096);
    check("blink_last_lit", {28'b0, led_out}, 32'hF);
    rd(2'd2, "status_phase0_lit", 32'h1F);
    wait_cyc(4097);
    check("blink_dark_again", {28'b0, led_out}, 32'h0);
    rd(2'd2, "status_phase0_dark", 32'h10);

    // Read in the same cycle as a write returns the old value; CTRL[31:8] read 0.
    wait_cyc(4098);
    bus.address    = 2'd0;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 32'hABCD_0002;
    #1;
    check("read_during_write_old", bus.readdata, 32'h55);
    @(posedge clk);
    #1;
    check("ctrl_after_write", bus.readdata, 32'h02);
    @(negedge clk);
    bus.write_n = 1'b1;
    led_req     = 4'h1;

    bus_write(2'd1, 32'h0000_0040);
    rd(2'd1, "duty_readback", 32'h40);
    wait_cyc(4104);
    rd(2'd2, "status_before_clear", 32'h10);
    bus_write(2'd2, 32'h0);
    rd(2'd2, "status_cleared", 32'h00);

    wait_cyc(4200);
    s0 = lit_total;
    wait_cyc(4607);
    rd(2'd2, "status_clear_holds", 32'h00);
    wait_cyc(4608);
    rd(2'd2, "status_wrap_again", 32'h10);
    check("pwm_dark_at_wrap", {28'b0, led_out}, 32'h0);
    s1 = lit_total;
    check("pwm_dark_before_shadow_load", s1 - s0, 0);

    wait_cyc(4609);
    check("pwm_first_lit", {28'b0, led_out}, 32'h1);
    a = lit_total;
    len = exp_lit(32'h40);
    wait_cyc(4608 + len);
    check("pwm_last_lit", {28'b0, led_out}, 32'h1);
    wait_cyc(4609 + len);
    check("pwm_first_dark", {28'b0, led_out}, 32'h0);
    wait_cyc(5121);
    b = lit_total;
    check("pwm_period_duty40", b - a, exp_lit(32'h40));

    // Mid-period DUTY rewrite must not disturb the running period.
    wait_cyc(5200);
    bus_write(2'd1, 32'h0000_00C0);
    wait_cyc(5633);
    c = lit_total;
    check("duty_mid_write_kept", c - b, exp_lit(32'h40));

    // This write lands exactly on the wrap edge (cycle 6144).
    wait_cyc(6143);
    bus_write(2'd1, 32'h0000_0010);
    wait_cyc(6145);
    d = lit_total;
    check("duty_c0_applied", d - c, exp_lit(32'hC0));
    wait_cyc(6657);
    e = lit_total;
    check("duty_coincident_deferred", e - d, exp_lit(32'hC0));
    wait_cyc(7169);
    f = lit_total;
    check("duty_10_applied", f - e, exp_lit(32'h10));
    check("pre_reset_lit", {28'b0, led_out}, 32'h1);

    // Asynchronous reset mid-period.
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_dark", {28'b0, led_out}, 32'h0);
    rd(2'd1, "duty_in_reset", 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    wait_cyc(1);
    check("ctrl_reset_follow", {28'b0, led_out}, 32'h1);
    wait_cyc(2);
    bus_write(2'd0, 32'h02);
    wait_cyc(5);
    g = lit_total;
    wait_cyc(10);
    bus_write(2'd1, 32'h0000_0020);
    wait_cyc(513);
    h = lit_total;
    check("no_light_after_reset", h - g, 0);
    len = exp_lit(32'h20);
    wait_cyc(512 + len);
    check("restart_last_lit", {28'b0, led_out}, 32'h1);
    wait_cyc(513 + len);
    check("restart_first_dark", {28'b0, led_out}, 32'h0);
    wait_cyc(1025);
    i = lit_total;
    check("restart_period_duty20", i - h, exp_lit(32'h20));

    // Full-scale duty is never lit for the whole period.
    wait_cyc(1030);
    bus_write(2'd1, 32'h0000_00FF);
    wait_cyc(1537);
    j = lit_total;
    wait_cyc(2049);
    k = lit_total;
    check("duty_ff_period", k - j, exp_lit(32'hFF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
